// File: rtl/complex_arith_pipe.sv
// complex_arith_pipe
//   Two-stage pipelined complex arithmetic unit. Operands are two's complement
//   N-bit real/imaginary components. For the multiply ops they are read as
//   signed Q1.(N-1) fractions.
//   Ops: 00 a+b, 01 a-b, 10 a*b, 11 a*conj(b). Latency is 2 cycles for every
//   op, and throughput is one operand set per cycle. A valid/ready handshake
//   is used on both sides. The whole pipe freezes while a finished result is
//   waiting and the consumer is not ready.
//
// Build option:
//   COMPLEX_ARITH_SAT_EN  defined   -> an overflowing component clamps to the
//                                      N-bit max/min.
//                         undefined -> an overflowing component wraps (keeps
//                                      its low N bits).
//   ovf is reported the same way in both builds.
//
// Ports:
//   clk             in   clock, rising edge
//   rst_n           in   synchronous active-low reset
//   in_valid        in   operand set offered
//   in_ready        out  operand set accepted this cycle (combinational)
//   op[1:0]         in   operation select
//   areal, aimaginary, breal, bimaginary  in  [N-1:0] operands
//   out_valid       out  result registers hold a valid result
//   out_ready       in   consumer takes the result this cycle
//   resultreal, resultimaginary  out [N-1:0] result components
//   ovf             out  either result component overflowed N bits
module complex_arith_pipe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] areal,
  input  logic [N-1:0] aimaginary,
  input  logic [N-1:0] breal,
  input  logic [N-1:0] bimaginary,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] resultreal,
  output logic [N-1:0] resultimaginary,
  output logic         ovf
);

  // A value fits in N bits only when its top three bits (N+1..N-1) agree.
  function automatic logic out_of_range_f(input logic signed [N+1:0] v);
    return !((v[N+1:N-1] == 3'b000) || (v[N+1:N-1] == 3'b111));
  endfunction

  function automatic logic [N-1:0] reduce_f(input logic signed [N+1:0] v);
    logic [N-1:0] r;
    r = v[N-1:0];
`ifdef COMPLEX_ARITH_SAT_EN
    if (out_of_range_f(v))
      r = v[N+1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
    return r;
  endfunction

  logic                  vld_p1_q;
  logic [1:0]            op_p1_q;
  logic signed [N:0]     sum_re_p1_q, sum_im_p1_q;
  logic signed [2*N-1:0] prod_rr_p1_q, prod_ii_p1_q, prod_ri_p1_q, prod_ir_p1_q;

  logic                  vld_p2_q;
  logic [N-1:0]          res_re_p2_q, res_im_p2_q;
  logic                  ovf_p2_q;

  // The only stall source is a result that is waiting and has no taker.
  // Every stage advances together whenever that is not the case.
  assign in_ready = !(vld_p2_q && !out_ready);

  // ---- stage 0: operand widening, add/sub and partial products ----
  logic signed [N:0]     a_re_x, a_im_x, b_re_x, b_im_x;
  logic signed [N:0]     sum_re_p1_d, sum_im_p1_d;
  logic signed [2*N-1:0] ar_w, ai_w, br_w, bi_w;

  assign a_re_x = $signed({areal[N-1], areal});
  assign a_im_x = $signed({aimaginary[N-1], aimaginary});
  assign b_re_x = $signed({breal[N-1], breal});
  assign b_im_x = $signed({bimaginary[N-1], bimaginary});
  assign sum_re_p1_d = op[0] ? (a_re_x - b_re_x) : (a_re_x + b_re_x);
  assign sum_im_p1_d = op[0] ? (a_im_x - b_im_x) : (a_im_x + b_im_x);

  // Sign-extend to 2N first so each product is exact at 2N bits.
  assign ar_w = $signed({{N{areal[N-1]}}, areal});
  assign ai_w = $signed({{N{aimaginary[N-1]}}, aimaginary});
  assign br_w = $signed({{N{breal[N-1]}}, breal});
  assign bi_w = $signed({{N{bimaginary[N-1]}}, bimaginary});

  always_ff @(posedge clk) begin
    if (!rst_n)        vld_p1_q <= 1'b0;
    else if (in_ready) vld_p1_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      op_p1_q      <= op;
      sum_re_p1_q  <= sum_re_p1_d;
      sum_im_p1_q  <= sum_im_p1_d;
      prod_rr_p1_q <= ar_w * br_w;
      prod_ii_p1_q <= ai_w * bi_w;
      prod_ri_p1_q <= ar_w * bi_w;
      prod_ir_p1_q <= ai_w * br_w;
    end
  end

  // ---- stage 1: combine products, scale, reduce to N bits ----
  logic signed [2*N:0] rr_x, ii_x, ri_x, ir_x;
  logic signed [2*N:0] mul_re_full, mul_im_full;
  logic signed [N+1:0] mul_re_sc, mul_im_sc;
  logic signed [N+1:0] full_re, full_im;
  logic [N-1:0]        res_re_p2_d, res_im_p2_d;
  logic                ovf_p2_d;

  assign rr_x = $signed({prod_rr_p1_q[2*N-1], prod_rr_p1_q});
  assign ii_x = $signed({prod_ii_p1_q[2*N-1], prod_ii_p1_q});
  assign ri_x = $signed({prod_ri_p1_q[2*N-1], prod_ri_p1_q});
  assign ir_x = $signed({prod_ir_p1_q[2*N-1], prod_ir_p1_q});

  always_comb begin
    mul_re_full = rr_x - ii_x;
    mul_im_full = ri_x + ir_x;
    if (op_p1_q[0]) begin
      mul_re_full = rr_x + ii_x;
      mul_im_full = ir_x - ri_x;
    end
  end

  // Dropping the low N-1 bits is the arithmetic shift right by N-1, so the
  // result truncates toward negative infinity. N+2 bits keep the range.
  assign mul_re_sc = mul_re_full[2*N:N-1];
  assign mul_im_sc = mul_im_full[2*N:N-1];

  always_comb begin
    full_re = $signed({sum_re_p1_q[N], sum_re_p1_q});
    full_im = $signed({sum_im_p1_q[N], sum_im_p1_q});
    if (op_p1_q[1]) begin
      full_re = mul_re_sc;
      full_im = mul_im_sc;
    end
    res_re_p2_d = reduce_f(full_re);
    res_im_p2_d = reduce_f(full_im);
    ovf_p2_d    = out_of_range_f(full_re) | out_of_range_f(full_im);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2_q    <= 1'b0;
      res_re_p2_q <= '0;
      res_im_p2_q <= '0;
      ovf_p2_q    <= 1'b0;
    end else if (in_ready) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        res_re_p2_q <= res_re_p2_d;
        res_im_p2_q <= res_im_p2_d;
        ovf_p2_q    <= ovf_p2_d;
      end
    end
  end

  // ---- outputs ----
  assign out_valid       = vld_p2_q;
  assign resultreal      = res_re_p2_q;
  assign resultimaginary = res_im_p2_q;
  assign ovf             = ovf_p2_q;

endmodule

// File: tb/tb_complex_arith_pipe.sv
module tb_complex_arith_pipe;

`ifdef COMPLEX_ARITH_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [1:0] op;
  logic [7:0] areal, aimaginary, breal, bimaginary, resultreal, resultimaginary;

  complex_arith_pipe #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .areal(areal), .aimaginary(aimaginary), .breal(breal),
    .bimaginary(bimaginary), .out_valid(out_valid), .out_ready(out_ready),
    .resultreal(resultreal), .resultimaginary(resultimaginary), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    int ar, ai, br, bi;
    int er, ei;
    int eo;
  } vec_t;

  vec_t vecs[12];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int k);
    op         = vecs[k].op;
    areal      = 8'(vecs[k].ar);
    aimaginary = 8'(vecs[k].ai);
    breal      = 8'(vecs[k].br);
    bimaginary = 8'(vecs[k].bi);
  endtask

  task automatic chk_res(input string name, input int k);
    chk({name, " re"},  int'($signed(resultreal)),      vecs[k].er);
    chk({name, " im"},  int'($signed(resultimaginary)), vecs[k].ei);
    chk({name, " ovf"}, int'(ovf),                      vecs[k].eo);
  endtask

  initial begin
    int q[$];
    int sidx[4];
    int sent, got, head;
    bit prev_stall;
    logic [7:0] sv_re, sv_im;
    logic sv_ovf;

    // op, a, b, expected result, expected ovf
    vecs[0]  = '{2'd0,  100,   20,   50,  -30, SAT ? 127 : -106, -10, 1};
    vecs[1]  = '{2'd1,   10,    5,   20,   -3, -10,   8, 0};
    vecs[2]  = '{2'd2,   64,    0,    0,   64,   0,  32, 0};
    vecs[3]  = '{2'd2, -128,    0, -128,    0, SAT ? 127 : -128, 0, 1};
    vecs[4]  = '{2'd3,    0,   64,    0,   64,  32,   0, 0};
    vecs[5]  = '{2'd0,    3,    4,   -5,    7,  -2,  11, 0};
    vecs[6]  = '{2'd1, -100, -100,  100,  100, SAT ? -128 : 56, SAT ? -128 : 56, 1};
    vecs[7]  = '{2'd2,   32,   32,   32,  -32,  16,   0, 0};
    vecs[8]  = '{2'd2,   -1,    0,    1,    0,  -1,   0, 0};
    vecs[9]  = '{2'd3,   64,   64,   64,  -64,   0,  64, 0};
    vecs[10] = '{2'd0, -128,    0,   -1,    0, SAT ? -128 : 127, 0, 1};
    vecs[11] = '{2'd1,  127,    0,   -1,    0, SAT ? 127 : -128, 0, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 2'b00;
    areal = 8'h00; aimaginary = 8'h00; breal = 8'h00; bimaginary = 8'h00;

    repeat (3) @(negedge clk);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset re",  int'(resultreal), 0);
    chk("reset im",  int'(resultimaginary), 0);
    chk("reset ovf", int'(ovf), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after release", int'(in_ready), 1);

    // Single transactions: latency and values
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(i);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      op = ~op;
      areal = 8'h5a;
      chk($sformatf("vec%0d out_valid at 1", i), int'(out_valid), 0);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid at 2", i), int'(out_valid), 1);
      chk_res($sformatf("vec%0d", i), i);
    end

    // Streamed sets with consumer stall in cycles 3..5
    sidx = '{1, 2, 4, 5};
    sent = 0; got = 0; prev_stall = 1'b0;
    sv_re = '0; sv_im = '0; sv_ovf = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 5);
      if (sent < 4) begin
        drive(sidx[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
        op = 2'b11;
        areal = 8'h77; breal = 8'h33;
      end
      #1;
      if (c >= 3 && c <= 5) begin
        chk($sformatf("stream c%0d out_valid", c), int'(out_valid), 1);
        chk($sformatf("stream c%0d in_ready", c), int'(in_ready), 0);
      end else if (c < 12) begin
        chk($sformatf("stream c%0d in_ready", c), int'(in_ready), 1);
      end
      if (prev_stall) begin
        chk($sformatf("stall c%0d re", c),  int'(resultreal), int'(sv_re));
        chk($sformatf("stall c%0d im", c),  int'(resultimaginary), int'(sv_im));
        chk($sformatf("stall c%0d ovf", c), int'(ovf), int'(sv_ovf));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk($sformatf("stream c%0d unexpected result", c), 1, 0);
        end else begin
          head = q.pop_front();
          chk_res($sformatf("stream c%0d", c), head);
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(sidx[sent]);
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      sv_re = resultreal; sv_im = resultimaginary; sv_ovf = ovf;
    end
    chk("stream sent", sent, 4);
    chk("stream got", got, 4);
    chk("stream drained out_valid", int'(out_valid), 0);

    // Reset with two sets in flight
    @(negedge clk);
    out_ready = 1'b1;
    drive(1); in_valid = 1'b1;
    @(negedge clk);
    drive(5);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("midreset out_valid", int'(out_valid), 0);
    chk("midreset re", int'(resultreal), 0);
    chk("midreset ovf", int'(ovf), 0);
    chk("midreset in_ready", int'(in_ready), 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post reset c%0d out_valid", c), int'(out_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
